// File: rtl/rl_lut_addr_gen_pkg.sv
// Shared constants for the range-limited force LUT front end and the c1/c0 LUT wrappers.
// Also holds the IEEE-754 single-precision field layout used by the decode stage.
package rl_lut_addr_gen_pkg;

    localparam int DEF_SEGMENT_NUM = 14;
    localparam int DEF_BIN_NUM     = 256;
    localparam int DEF_BIN_WIDTH   = $clog2(DEF_BIN_NUM);
    localparam int DEF_EXP_MIN     = 115;
    localparam int DEF_ADDR_WIDTH  = 12;
    localparam int DEF_LUT_LATENCY = 1;
    localparam int DEF_CNT_WIDTH   = 32;
    localparam int LUT_DEPTH       = DEF_SEGMENT_NUM * DEF_BIN_NUM;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } f32_t;

endpackage

// File: rtl/rl_lut_addr_gen_if.sv
// Sample stream in, LUT read port and aligned sample stream out of the LUT address generator.
// The generator takes the slave side; a driver/monitor takes the master side.
interface rl_lut_addr_gen_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  r2_valid;
    logic [31:0]           r2;
    logic [ADDR_WIDTH-1:0] lut_address;
    logic                  lut_rden;
    logic [31:0]           r2_out;
    logic                  valid_out;
    logic                  oor_out;

    modport master (
        output r2_valid, r2,
        input  lut_address, lut_rden, r2_out, valid_out, oor_out
    );

    modport slave (
        input  r2_valid, r2,
        output lut_address, lut_rden, r2_out, valid_out, oor_out
    );
endinterface

// File: rtl/rl_valid_delay.sv
// Valid-qualified shift register: data only advances alongside a valid bit, so the
// payload holds its last value across bubbles instead of toggling.
module rl_valid_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_valid = i_valid;
            assign o_data  = i_data;
        end else begin : g_shift
            logic [DEPTH-1:0] r_valid;
            logic [WIDTH-1:0] r_data [DEPTH];

            // NOTE: the payload stages are reset too, because the aligned sample is a
            // block output that must read 0 straight out of reset, not just its valid.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        r_data[i] <= '0;
                    end
                end else begin
                    r_valid[0] <= i_valid;
                    if (i_valid) begin
                        r_data[0] <= i_data;
                    end
                    for (int i = 1; i < DEPTH; i++) begin
                        r_valid[i] <= r_valid[i-1];
                        if (r_valid[i-1]) begin
                            r_data[i] <= r_data[i-1];
                        end
                    end
                end
            end

            assign o_valid = r_valid[DEPTH-1];
            assign o_data  = r_data[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/rl_lut_addr_gen.sv
// Decodes a single-precision r2 into a {segment, bin} coefficient LUT address, flags
// out-of-range samples, aligns r2 with the LUT q and keeps in/out-of-range statistics.
module rl_lut_addr_gen
    import rl_lut_addr_gen_pkg::*;
#(
    parameter int SEGMENT_NUM = DEF_SEGMENT_NUM,
    parameter int BIN_NUM     = DEF_BIN_NUM,
    parameter int EXP_MIN     = DEF_EXP_MIN,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int LUT_LATENCY = DEF_LUT_LATENCY,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cnt_clr,
    rl_lut_addr_gen_if.slave     bus,
    output logic [CNT_WIDTH-1:0] cnt_inrange,
    output logic [CNT_WIDTH-1:0] cnt_oor
);

    localparam int         BIN_WIDTH = $clog2(BIN_NUM);
    localparam int         SEG_WIDTH = $clog2(SEGMENT_NUM);
    localparam logic [7:0] EXP_LO    = 8'(EXP_MIN);
    localparam logic [7:0] EXP_HI    = 8'(EXP_MIN + SEGMENT_NUM);

    f32_t                  w_in;
    logic                  w_in_oor;
    logic [SEG_WIDTH-1:0]  w_seg;
    logic [ADDR_WIDTH-1:0] w_in_addr;

    // Sign, zero/denormal (exp below segment 0) and Inf/NaN (exp above the cutoff) all land here.
    assign w_in      = f32_t'(bus.r2);
    assign w_in_oor  = w_in.sign | (w_in.exp < EXP_LO) | (w_in.exp >= EXP_HI);
    assign w_seg     = SEG_WIDTH'(w_in.exp - EXP_LO);
    assign w_in_addr = ADDR_WIDTH'({w_seg, w_in.mant[22 -: BIN_WIDTH]});

    logic                  r_s1_valid, r_s1_oor;
    logic [31:0]           r_s1_r2;
    logic [ADDR_WIDTH-1:0] r_s1_addr;

    // NOTE: every clocked process uses non-blocking assignments so all stages sample
    // the pre-edge values of their neighbours regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_oor   <= 1'b0;
            r_s1_r2    <= '0;
            r_s1_addr  <= '0;
        end else begin
            r_s1_valid <= bus.r2_valid;
            if (bus.r2_valid) begin
                r_s1_r2   <= w_in;
                r_s1_oor  <= w_in_oor;
                r_s1_addr <= w_in_oor ? '0 : w_in_addr;
            end
        end
    end

    logic                  r_s2_valid, r_s2_oor, r_s2_rden;
    logic [31:0]           r_s2_r2;
    logic [ADDR_WIDTH-1:0] r_s2_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_oor   <= 1'b0;
            r_s2_rden  <= 1'b0;
            r_s2_r2    <= '0;
            r_s2_addr  <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_rden  <= r_s1_valid & ~r_s1_oor;
            if (r_s1_valid) begin
                r_s2_oor  <= r_s1_oor;
                r_s2_r2   <= r_s1_r2;
                r_s2_addr <= r_s1_addr;
            end
        end
    end

    assign bus.lut_address = r_s2_addr;
    assign bus.lut_rden    = r_s2_rden;

    logic [32:0] w_out_data;

    rl_valid_delay #(
        .WIDTH (33),
        .DEPTH (LUT_LATENCY)
    ) u_align (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (r_s2_valid),
        .i_data  ({r_s2_oor, r_s2_r2}),
        .o_valid (bus.valid_out),
        .o_data  (w_out_data)
    );

    assign {bus.oor_out, bus.r2_out} = w_out_data;

    logic [CNT_WIDTH-1:0] r_cnt_inrange, r_cnt_oor;

    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_inrange <= '0;
            r_cnt_oor     <= '0;
        end else if (cnt_clr) begin
            r_cnt_inrange <= '0;
            r_cnt_oor     <= '0;
        end else if (bus.r2_valid) begin
            if (!w_in_oor && !(&r_cnt_inrange)) begin
                r_cnt_inrange <= r_cnt_inrange + CNT_WIDTH'(1);
            end
            if (w_in_oor && !(&r_cnt_oor)) begin
                r_cnt_oor <= r_cnt_oor + CNT_WIDTH'(1);
            end
        end
    end

    assign cnt_inrange = r_cnt_inrange;
    assign cnt_oor     = r_cnt_oor;

endmodule

// File: tb/tb_rl_lut_addr_gen.sv
// Self-checking bench for rl_lut_addr_gen: a per-cycle history model derives address,
// read enable, aligned outputs and counters; directed probes pin the model to literals.
module tb_rl_lut_addr_gen;
    import rl_lut_addr_gen_pkg::*;

    localparam int L    = DEF_LUT_LATENCY;
    localparam int HIST = 4096;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [31:0] cnt_inrange, cnt_oor;
    logic [2:0]  sat_inrange, sat_oor;

    rl_lut_addr_gen_if #(.ADDR_WIDTH(12)) bus   ();
    rl_lut_addr_gen_if #(.ADDR_WIDTH(12)) bus_s ();

    assign bus_s.r2_valid = bus.r2_valid;
    assign bus_s.r2       = bus.r2;

    rl_lut_addr_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cnt_clr     (cnt_clr),
        .bus         (bus),
        .cnt_inrange (cnt_inrange),
        .cnt_oor     (cnt_oor)
    );

    // Narrow-counter copy on the same stream so saturation is reachable in a short run.
    rl_lut_addr_gen #(.CNT_WIDTH(3)) dut_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .cnt_clr     (cnt_clr),
        .bus         (bus_s),
        .cnt_inrange (sat_inrange),
        .cnt_oor     (sat_oor)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference rules: in range iff positive and 2^-12 <= r2 < 4.0 (biased exp 115..128).
    function automatic logic model_oor(input logic [31:0] x);
        int ex;
        ex = int'(x[30:23]);
        return x[31] || (ex < 115) || (ex > 128);
    endfunction

    function automatic int model_addr(input logic [31:0] x);
        return (int'(x[30:23]) - 115) * 256 + int'(x[22:15]);
    endfunction

    int          e = 0;
    logic        hist_v  [HIST];
    logic [31:0] hist_r2 [HIST];
    longint      m_inr = 0, m_oor = 0;
    int          ms_inr = 0, ms_oor = 0;
    logic [31:0] m_last_r2 = '0;
    int          n_vout = 0;

    initial begin
        for (int i = 0; i < HIST; i++) begin
            hist_v[i]  = 1'b0;
            hist_r2[i] = '0;
        end
    end

    // Record what the DUT samples at every edge and advance the counter model.
    always @(posedge clk) begin
        e++;
        if (e >= HIST) begin
            $display("FAIL history_overflow: edge %0d, limit %0d", e, HIST);
            $fatal(1);
        end
        if (!rst_n) begin
            hist_v[e] = 1'b0;
        end else begin
            hist_v[e]  = bus.r2_valid;
            hist_r2[e] = bus.r2;
            if (cnt_clr) begin
                m_inr = 0; m_oor = 0; ms_inr = 0; ms_oor = 0;
            end else if (bus.r2_valid) begin
                if (model_oor(bus.r2)) begin
                    if (m_oor < 64'hFFFF_FFFF) m_oor++;
                    if (ms_oor < 7) ms_oor++;
                end else begin
                    if (m_inr < 64'hFFFF_FFFF) m_inr++;
                    if (ms_inr < 7) ms_inr++;
                end
            end
        end
    end

    always @(negedge rst_n) begin
        for (int i = 0; i < HIST; i++) hist_v[i] = 1'b0;
        m_inr = 0; m_oor = 0; ms_inr = 0; ms_oor = 0;
        m_last_r2 = '0;
    end

    int   ia, iv;
    logic exp_rden;

    always @(negedge clk) begin
        if (rst_n && e > L + 1) begin
            ia       = e - 1;
            iv       = e - 1 - L;
            exp_rden = hist_v[ia] && !model_oor(hist_r2[ia]);
            check("lut_rden", bus.lut_rden, exp_rden);
            if (exp_rden) check("lut_address", bus.lut_address, model_addr(hist_r2[ia]));
            else if (hist_v[ia]) check("lut_address_oor", bus.lut_address, 0);
            check("valid_out", bus.valid_out, hist_v[iv]);
            if (hist_v[iv]) begin
                m_last_r2 = hist_r2[iv];
                check("oor_out", bus.oor_out, model_oor(hist_r2[iv]));
            end
            check("r2_out", bus.r2_out, m_last_r2);
            check("cnt_inrange", cnt_inrange, m_inr);
            check("cnt_oor", cnt_oor, m_oor);
            check("sat_inrange", sat_inrange, ms_inr);
            check("sat_oor", sat_oor, ms_oor);
        end
        if (bus.valid_out === 1'b1) n_vout++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample, then check the address 2 edges and the aligned output 3 edges later.
    task automatic probe(input logic [31:0] x, input logic [11:0] addr, input logic rden,
                         input logic oor);
        bus.r2_valid = 1'b1;
        bus.r2       = x;
        tick();
        bus.r2_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("probe_rden", bus.lut_rden, rden);
        check("probe_addr", bus.lut_address, addr);
        @(negedge clk);
        check("probe_valid_out", bus.valid_out, 1'b1);
        check("probe_oor_out", bus.oor_out, oor);
        check("probe_r2_out", bus.r2_out, x);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_lut_address"}, bus.lut_address, 0);
        check({tag, "_lut_rden"}, bus.lut_rden, 0);
        check({tag, "_valid_out"}, bus.valid_out, 0);
        check({tag, "_r2_out"}, bus.r2_out, 0);
        check({tag, "_oor_out"}, bus.oor_out, 0);
        check({tag, "_cnt_inrange"}, cnt_inrange, 0);
        check({tag, "_cnt_oor"}, cnt_oor, 0);
    endtask

    logic [31:0] oor_vec [9] = '{32'h4080_0000, 32'hBF80_0000, 32'h0000_0000, 32'h7FC0_0000,
                                 32'h8000_0000, 32'h7F80_0000, 32'h0000_0001, 32'h3900_0000,
                                 32'h4100_0000};
    int sent, vout_mark;

    initial begin
        bus.r2_valid = 1'b0;
        bus.r2       = '0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Basic decode and segment boundaries.
        probe(32'h3F80_0000, 12'hC00, 1'b1, 1'b0);
        check("cnt_inrange_after_1", cnt_inrange, 1);
        probe(32'h3FC0_0000, 12'hC80, 1'b1, 1'b0);
        probe(32'h3980_0000, 12'h000, 1'b1, 1'b0);
        probe(32'h407F_FFFF, 12'hDFF, 1'b1, 1'b0);

        // Out-of-range classes: cutoff, negative, zero, NaN.
        for (int i = 0; i < 4; i++) probe(oor_vec[i], 12'h000, 1'b0, 1'b1);
        check("cnt_oor_after_4", cnt_oor, 4);
        check("cnt_inrange_after_4", cnt_inrange, 4);

        // Random in-range stream with bubbles.
        cnt_clr = 1'b1;
        tick();
        cnt_clr   = 1'b0;
        vout_mark = n_vout;
        sent      = 0;
        while (sent < 1000) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.r2_valid = 1'b0;
            end else begin
                bus.r2_valid = 1'b1;
                bus.r2       = {1'b0, 8'(115 + $urandom_range(0, 13)), 23'($urandom)};
                sent++;
            end
            tick();
        end
        bus.r2_valid = 1'b0;
        repeat (5) tick();
        check("stream_valid_out_count", n_vout - vout_mark, 1000);
        check("stream_cnt_inrange", cnt_inrange, 1000);
        check("stream_cnt_oor", cnt_oor, 0);
        check("stream_sat_inrange", sat_inrange, 7);

        // Reset while samples occupy the pipeline.
        vout_mark    = n_vout;
        bus.r2_valid = 1'b1;
        bus.r2       = 32'h3F80_0000;
        tick();
        bus.r2 = 32'h4000_0000;
        tick();
        bus.r2 = 32'h3FC0_0000;
        #2;
        rst_n        = 1'b0;
        bus.r2_valid = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) tick();
        check("midreset_no_valid_out", n_vout - vout_mark, 0);
        check("midreset_cnt_inrange", cnt_inrange, 0);

        // Saturation of the narrow counter, then clear against a same-cycle sample.
        for (int i = 0; i < 9; i++) begin
            bus.r2_valid = 1'b1;
            bus.r2       = oor_vec[i];
            tick();
        end
        bus.r2_valid = 1'b0;
        repeat (3) tick();
        check("sat_oor_held", sat_oor, 7);
        check("cnt_oor_9", cnt_oor, 9);
        cnt_clr      = 1'b1;
        bus.r2_valid = 1'b1;
        bus.r2       = 32'hBF80_0000;
        tick();
        cnt_clr      = 1'b0;
        bus.r2_valid = 1'b0;
        check("clr_cnt_oor", cnt_oor, 0);
        check("clr_sat_oor", sat_oor, 0);
        probe(32'h4080_0000, 12'h000, 1'b0, 1'b1);
        check("after_clr_cnt_oor", cnt_oor, 1);

        repeat (4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
